// File: rtl/ecc_scrub_scheduler_if.sv
// Scrub handshake between the scheduler and the per-bank ECC scrubbers.
// The scheduler side uses the master modport; the scrubbers (or a bench) use slave.
interface ecc_scrub_scheduler_if #(
  parameter int NumBanks = 4
);
  logic [NumBanks-1:0] scrub_trigger;
  logic [NumBanks-1:0] scrub_done;
  logic [NumBanks-1:0] bit_corrected;
  logic [NumBanks-1:0] uncorrectable;

  modport master (
    output scrub_trigger,
    input  scrub_done,
    input  bit_corrected,
    input  uncorrectable
  );

  modport slave (
    input  scrub_trigger,
    output scrub_done,
    output bit_corrected,
    output uncorrectable
  );
endinterface

// File: rtl/ecc_scrub_scheduler.sv
// Round-robin background scrub scheduler with boost-after-error interval,
// scrub timeout, saturating error counters and a sticky interrupt.
//   state   | meaning
//   S_IDLE  | scheduling disabled, waiting for enable_i
//   S_COUNT | counting down the idle interval before the next scrub
//   S_WAIT  | trigger held on the current bank until done or timeout
module ecc_scrub_scheduler #(
  parameter int NumBanks      = 4,
  parameter int IntervalWidth = 16,
  parameter int CntWidth      = 16,
  parameter int BoostScrubs   = 16,
  parameter int TimeoutCycles = 1024,
  localparam int IdxW         = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [IntervalWidth-1:0] interval_i,
  input  logic [IntervalWidth-1:0] fast_interval_i,
  input  logic [CntWidth-1:0]      threshold_i,
  input  logic                     clear_i,
  ecc_scrub_scheduler_if.master    bus,
  output logic [IdxW-1:0]          bank_idx_o,
  output logic                     pass_done_o,
  output logic [CntWidth-1:0]      corrected_cnt_o,
  output logic [CntWidth-1:0]      uncorrectable_cnt_o,
  output logic                     boost_o,
  output logic                     timeout_o,
  output logic                     irq_o
);

  localparam int WaitW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int BoostW = $clog2(BoostScrubs + 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_WAIT} state_e;

  state_e                   r_state;
  logic [IntervalWidth-1:0] r_cnt;
  logic [WaitW-1:0]         r_wait_cnt;
  logic [NumBanks-1:0]      r_trig;
  logic [IdxW-1:0]          r_idx;
  logic                     r_pass_done;
  logic                     r_timeout;
  logic [BoostW-1:0]        r_boost_cnt;
  logic [CntWidth-1:0]      r_corr_cnt;
  logic [CntWidth-1:0]      r_unc_cnt;
  logic                     r_irq;

  logic                     w_boost;
  logic [IntervalWidth-1:0] w_eff_interval;
  logic                     w_done;
  logic                     w_timeout;
  logic                     w_idx_last;
  logic [IdxW-1:0]          w_idx_next;
  logic [CntWidth:0]        w_corr_sum;
  logic [CntWidth:0]        w_unc_sum;
  logic                     w_irq_set;

  function automatic logic [CntWidth:0] popcount(input logic [NumBanks-1:0] v);
    logic [CntWidth:0] s;
    s = '0;
    for (int i = 0; i < NumBanks; i++) s = s + (CntWidth+1)'(v[i]);
    return s;
  endfunction

  assign w_boost        = (r_boost_cnt != '0);
  assign w_eff_interval = w_boost ? fast_interval_i : interval_i;
  assign w_done         = bus.scrub_done[r_idx];
  assign w_timeout      = (r_wait_cnt == WaitW'(TimeoutCycles - 1));
  assign w_idx_last     = (r_idx == IdxW'(NumBanks - 1));
  assign w_idx_next     = w_idx_last ? '0 : r_idx + IdxW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wait_cnt  <= '0;
      r_trig      <= '0;
      r_idx       <= '0;
      r_pass_done <= 1'b0;
      r_timeout   <= 1'b0;
      r_boost_cnt <= '0;
    end else begin
      r_pass_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            r_state <= S_COUNT;
            r_cnt   <= w_eff_interval;
          end
        end
        S_COUNT: begin
          if (!enable_i) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_state    <= S_WAIT;
            r_trig     <= NumBanks'(1) << r_idx;
            r_wait_cnt <= '0;
          end else begin
            r_cnt <= r_cnt - IntervalWidth'(1);
          end
        end
        S_WAIT: begin
          // A timeout retires the bank like a done, but does not consume a boost scrub
          if (w_done || w_timeout) begin
            r_trig      <= '0;
            r_idx       <= w_idx_next;
            r_pass_done <= w_idx_last;
            r_cnt       <= w_eff_interval;
            r_state     <= enable_i ? S_COUNT : S_IDLE;
            if (w_done && w_boost) r_boost_cnt <= r_boost_cnt - BoostW'(1);
            if (!w_done) r_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WaitW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (|bus.bit_corrected) r_boost_cnt <= BoostW'(BoostScrubs);
      if (clear_i) r_timeout <= 1'b0;
    end
  end

  assign w_corr_sum = {1'b0, r_corr_cnt} + popcount(bus.bit_corrected);
  assign w_unc_sum  = {1'b0, r_unc_cnt} + popcount(bus.uncorrectable);
  assign w_irq_set  = (r_unc_cnt != '0) ||
                      ((threshold_i != '0) && (r_corr_cnt >= threshold_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_corr_cnt <= '0;
      r_unc_cnt  <= '0;
      r_irq      <= 1'b0;
    end else if (clear_i) begin
      r_corr_cnt <= '0;
      r_unc_cnt  <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_corr_cnt <= w_corr_sum[CntWidth] ? '1 : w_corr_sum[CntWidth-1:0];
      r_unc_cnt  <= w_unc_sum[CntWidth] ? '1 : w_unc_sum[CntWidth-1:0];
      r_irq      <= r_irq | w_irq_set;
    end
  end

  assign bus.scrub_trigger   = r_trig;
  assign bank_idx_o          = r_idx;
  assign pass_done_o         = r_pass_done;
  assign corrected_cnt_o     = r_corr_cnt;
  assign uncorrectable_cnt_o = r_unc_cnt;
  assign boost_o             = w_boost;
  assign timeout_o           = r_timeout;
  assign irq_o               = r_irq;

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// Self-checking bench for ecc_scrub_scheduler: directed scenarios plus random
// traffic, compared every cycle against a timestamp-level reference model.
module tb_ecc_scrub_scheduler;
  localparam int NB = 4;
  localparam int IW = 8;
  localparam int CW = 4;
  localparam int BS = 3;
  localparam int TO = 8;
  localparam int SAT = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          enable_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [IW-1:0] interval_i = '0;
  logic [IW-1:0] fast_interval_i = '0;
  logic [CW-1:0] threshold_i = '0;
  logic [1:0]    bank_idx_o;
  logic          pass_done_o;
  logic [CW-1:0] corrected_cnt_o;
  logic [CW-1:0] uncorrectable_cnt_o;
  logic          boost_o;
  logic          timeout_o;
  logic          irq_o;

  ecc_scrub_scheduler_if #(.NumBanks(NB)) bus ();

  ecc_scrub_scheduler #(
    .NumBanks(NB), .IntervalWidth(IW), .CntWidth(CW),
    .BoostScrubs(BS), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .interval_i(interval_i), .fast_interval_i(fast_interval_i),
    .threshold_i(threshold_i), .clear_i(clear_i), .bus(bus),
    .bank_idx_o(bank_idx_o), .pass_done_o(pass_done_o),
    .corrected_cnt_o(corrected_cnt_o), .uncorrectable_cnt_o(uncorrectable_cnt_o),
    .boost_o(boost_o), .timeout_o(timeout_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: scheduling tracked as a mode plus the cycle numbers of
  // the next trigger rise and the current rise.
  localparam int M_IDLE = 0, M_COUNT = 1, M_SCRUB = 2;
  int m_mode, m_next_rise, m_rise, m_bank, m_boost, m_corr, m_unc;
  bit m_irq, m_tmo, m_pass;

  task automatic model_reset();
    m_mode = M_IDLE; m_next_rise = 0; m_rise = 0; m_bank = 0; m_boost = 0;
    m_corr = 0; m_unc = 0; m_irq = 0; m_tmo = 0; m_pass = 0;
  endtask

  task automatic model_step(input int n);
    int  ival;
    int  boost_n;
    bit  fin, to, pass_n, irq_n;
    ival    = (m_boost > 0) ? int'(fast_interval_i) : int'(interval_i);
    boost_n = m_boost;
    pass_n  = 0;
    case (m_mode)
      M_IDLE: if (enable_i) begin m_mode = M_COUNT; m_next_rise = n + ival + 2; end
      M_COUNT: begin
        if (!enable_i) m_mode = M_IDLE;
        else if (n + 1 == m_next_rise) begin m_mode = M_SCRUB; m_rise = n + 1; end
      end
      default: begin
        fin = bus.scrub_done[m_bank];
        to  = !fin && (n - m_rise == TO - 1);
        if (fin || to) begin
          pass_n = (m_bank == NB - 1);
          m_bank = (m_bank + 1) % NB;
          if (to) m_tmo = 1;
          if (fin && m_boost > 0) boost_n = m_boost - 1;
          if (enable_i) begin m_mode = M_COUNT; m_next_rise = n + ival + 2; end
          else m_mode = M_IDLE;
        end
      end
    endcase
    if (bus.bit_corrected != '0) boost_n = BS;
    irq_n = m_irq || (m_unc != 0) || (threshold_i != 0 && m_corr >= int'(threshold_i));
    if (clear_i) begin
      m_corr = 0; m_unc = 0; m_irq = 0; m_tmo = 0;
    end else begin
      m_corr = m_corr + $countones(bus.bit_corrected);
      m_unc  = m_unc + $countones(bus.uncorrectable);
      if (m_corr > SAT) m_corr = SAT;
      if (m_unc > SAT) m_unc = SAT;
      m_irq = irq_n;
    end
    m_boost = boost_n;
    m_pass  = pass_n;
  endtask

  task automatic compare_outputs();
    chk("trigger", 32'(bus.scrub_trigger), 32'((m_mode == M_SCRUB) ? (1 << m_bank) : 0));
    chk("bank_idx", 32'(bank_idx_o), 32'(m_bank));
    chk("pass_done", 32'(pass_done_o), 32'(m_pass));
    chk("corr_cnt", 32'(corrected_cnt_o), 32'(m_corr));
    chk("unc_cnt", 32'(uncorrectable_cnt_o), 32'(m_unc));
    chk("boost", 32'(boost_o), 32'(m_boost > 0));
    chk("timeout", 32'(timeout_o), 32'(m_tmo));
    chk("irq", 32'(irq_o), 32'(m_irq));
  endtask

  // Stimulus knobs and responder state
  bit       cfg_en;
  int       cfg_lat;
  int       p_corr, p_unc, p_clr, p_noise, p_en_drop;
  logic [3:0] one_corr, one_unc;
  bit       one_clr;
  bit       resp_on;
  int       resp_lat, resp_age, resp_bank;
  int       rise_log[$];
  int       rise_bank_log[$];
  int       pass_cnt, hi_run, last_hi, en_cyc;

  function automatic int pick_lat();
    if (cfg_lat >= 0) return cfg_lat;
    return (int'($urandom_range(7)) == 0) ? 1000 : int'($urandom_range(4));
  endfunction

  task automatic step_cycles(input int k);
    logic [3:0] d, nz, c, u;
    for (int i = 0; i < k; i++) begin
      @(posedge clk_i);
      #1;
      compare_outputs();
      if (bus.scrub_trigger != '0) begin
        hi_run++;
        if (!resp_on) begin
          resp_on = 1; resp_age = 0; resp_lat = pick_lat();
          for (int b = 0; b < NB; b++) if (bus.scrub_trigger[b]) resp_bank = b;
          rise_log.push_back(cyc);
          rise_bank_log.push_back(resp_bank);
        end
      end else begin
        resp_on = 0;
        if (hi_run > 0) begin last_hi = hi_run; hi_run = 0; end
      end
      if (pass_done_o) pass_cnt++;
      d = '0;
      if (resp_on) begin
        if (resp_age == resp_lat) d[resp_bank] = 1'b1;
        resp_age++;
      end
      if (int'($urandom_range(99)) < p_noise) begin
        nz = 4'($urandom());
        if (resp_on) nz[resp_bank] = 1'b0;
        d = d | nz;
      end
      c = one_corr; u = one_unc;
      if (int'($urandom_range(99)) < p_corr) c = c | 4'($urandom());
      if (int'($urandom_range(99)) < p_unc) u = u | 4'($urandom());
      bus.scrub_done    = d;
      bus.bit_corrected = c;
      bus.uncorrectable = u;
      clear_i  = one_clr || (int'($urandom_range(99)) < p_clr);
      enable_i = cfg_en && !(int'($urandom_range(99)) < p_en_drop);
      if (enable_i && en_cyc < 0) en_cyc = cyc;
      one_corr = '0; one_unc = '0; one_clr = 0;
      model_step(cyc);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("rst_trigger", 32'(bus.scrub_trigger), 32'd0);
    chk("rst_idx", 32'(bank_idx_o), 32'd0);
    chk("rst_pass", 32'(pass_done_o), 32'd0);
    chk("rst_corr", 32'(corrected_cnt_o), 32'd0);
    chk("rst_unc", 32'(uncorrectable_cnt_o), 32'd0);
    chk("rst_boost", 32'(boost_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    model_reset();
    resp_on = 0; hi_run = 0; last_hi = 0; pass_cnt = 0; en_cyc = -1;
    rise_log.delete(); rise_bank_log.delete();
    enable_i = 0; clear_i = 0;
    bus.scrub_done = '0; bus.bit_corrected = '0; bus.uncorrectable = '0;
    one_corr = '0; one_unc = '0; one_clr = 0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_step(cyc);
  endtask

  task automatic wait_trig();
    bit got;
    got = (bus.scrub_trigger != '0);
    for (int i = 0; i < 200 && !got; i++) begin
      step_cycles(1);
      got = (bus.scrub_trigger != '0);
    end
    chk("trigger_seen", 32'(got), 32'd1);
  endtask

  task automatic quiet();
    p_corr = 0; p_unc = 0; p_clr = 0; p_noise = 0; p_en_drop = 0;
  endtask

  initial begin
    int n0;
    quiet();
    cfg_en = 0; cfg_lat = 2;
    #2;
    do_reset();

    // Round-robin at interval 3, done two cycles after each rise
    interval_i = 8'd3; fast_interval_i = 8'd1; threshold_i = '0;
    cfg_en = 1; cfg_lat = 2;
    step_cycles(40);
    chk("rise_count", 32'(rise_log.size()), 32'd5);
    if (rise_log.size() >= 5) begin
      chk("first_rise", 32'(rise_log[0] - en_cyc), 32'd5);
      for (int i = 0; i < 5; i++) chk("rise_bank", 32'(rise_bank_log[i]), 32'(i % NB));
      for (int i = 1; i < 5; i++) chk("rise_gap", 32'(rise_log[i] - rise_log[i-1]), 32'd7);
    end
    chk("pass_count", 32'(pass_cnt), 32'd1);

    // Two corrected errors at once with threshold 2, then boosted scrubbing
    threshold_i = 4'd2;
    one_corr = 4'b0101;
    step_cycles(1);
    step_cycles(1);
    chk("corr_two", 32'(corrected_cnt_o), 32'd2);
    chk("boost_on", 32'(boost_o), 32'd1);
    step_cycles(1);
    chk("irq_thresh", 32'(irq_o), 32'd1);
    step_cycles(60);

    // Uncorrectable pulse, then clear together with a corrected pulse
    one_clr = 1; step_cycles(2);
    one_unc = 4'b0010;
    step_cycles(3);
    chk("irq_unc", 32'(irq_o), 32'd1);
    one_clr = 1; one_corr = 4'b0001;
    step_cycles(2);
    chk("clr_corr", 32'(corrected_cnt_o), 32'd0);
    chk("clr_unc", 32'(uncorrectable_cnt_o), 32'd0);
    chk("clr_irq", 32'(irq_o), 32'd0);
    chk("clr_boost", 32'(boost_o), 32'd1);

    // Saturation of the corrected counter
    one_clr = 1; step_cycles(2);
    for (int i = 0; i < 5; i++) begin one_corr = 4'hf; step_cycles(1); end
    step_cycles(1);
    chk("corr_sat", 32'(corrected_cnt_o), 32'(SAT));

    // Done never returned: timeout after TO trigger cycles
    cfg_en = 0; do_reset();
    cfg_en = 1; cfg_lat = 1000; interval_i = 8'd3;
    wait_trig();
    step_cycles(9);
    chk("timeout_hi", 32'(last_hi), 32'(TO));
    chk("timeout_flag", 32'(timeout_o), 32'd1);
    chk("timeout_idx", 32'(bank_idx_o), 32'd1);

    // Enable dropped mid-scrub: scrub completes, no further trigger
    cfg_en = 0; do_reset();
    cfg_en = 1; cfg_lat = 4; interval_i = 8'd2;
    wait_trig();
    cfg_en = 0;
    n0 = rise_log.size();
    step_cycles(25);
    chk("drop_hi", 32'(last_hi), 32'd5);
    chk("drop_no_rise", 32'(rise_log.size()), 32'(n0));

    // Async reset mid-scrub
    cfg_en = 1; cfg_lat = 1000;
    wait_trig();
    step_cycles(2);
    do_reset();

    // Randomized traffic with periodic config changes and mid-scrub resets
    for (int blk = 0; blk < 6; blk++) begin
      interval_i      = 8'($urandom_range(4));
      fast_interval_i = 8'($urandom_range(2));
      threshold_i     = 4'($urandom_range(6));
      cfg_lat = -1; cfg_en = 1;
      p_corr = 3; p_unc = 1; p_clr = 2; p_noise = 10; p_en_drop = 5;
      step_cycles(250);
      if (blk % 2 == 1) begin
        wait_trig();
        step_cycles(int'($urandom_range(2)));
        do_reset();
      end
    end
    quiet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ecc_scrub_scheduler.md
# ecc_scrub_scheduler

Schedules background scrubbing across `NumBanks` ECC-protected memory banks, each fronted by its own ECC scrubber. It issues one scrub request at a time, round-robin, at a programmable interval, and uses a faster interval for a number of scrubs after a correctable error. It also keeps saturating error counters and raises an interrupt. It sits between the ECC configuration registers and the per-bank scrubbers' `scrub_trigger_i` and `bit_corrected_o`/`uncorrectable_o` signals.

## Interface
Parameters:
- `NumBanks`, 4: number of scrubbed banks (≥1).
- `IntervalWidth`, 16: width of the interval inputs.
- `CntWidth`, 16: width of the error counters and threshold.
- `BoostScrubs`, 16: number of scrubs that use `fast_interval_i` after a correctable error (≥1).
- `TimeoutCycles`, 1024: maximum cycles to wait for a scrub to complete (≥1).

Ports (direction, width, meaning):
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `enable_i`, in, 1: enables scheduling (level).
- `interval_i`, in, `IntervalWidth`: idle cycles between scrubs in normal mode.
- `fast_interval_i`, in, `IntervalWidth`: idle cycles between scrubs in boost mode.
- `threshold_i`, in, `CntWidth`: corrected-count interrupt threshold; 0 disables the threshold interrupt.
- `clear_i`, in, 1: single-cycle pulse that clears the counters, `irq_o` and `timeout_o`.
- `scrub_trigger_o`, out, `NumBanks`: per-bank scrub request, held until done; at most one bit is set.
- `scrub_done_i`, in, `NumBanks`: per-bank pulse, high in the cycle that scrubber leaves its Write state for Idle.
- `bit_corrected_i`, in, `NumBanks`: per-bank correctable-error-fixed pulses.
- `uncorrectable_i`, in, `NumBanks`: per-bank uncorrectable-error pulses.
- `bank_idx_o`, out, `$clog2(NumBanks)` (min 1): index of the current or next bank.
- `pass_done_o`, out, 1: single-cycle pulse when the index wraps from `NumBanks-1` to 0.
- `corrected_cnt_o`, out, `CntWidth`: saturating count of corrected errors.
- `uncorrectable_cnt_o`, out, `CntWidth`: saturating count of uncorrectable errors.
- `boost_o`, out, 1: boost mode is active.
- `timeout_o`, out, 1: sticky flag; a scrub timed out.
- `irq_o`, out, 1: level interrupt.

## Operation
- State machine with three states: IDLE, COUNT, WAIT.
- IDLE:
  - If `enable_i`, go to COUNT and load `cnt_q` with the effective interval: `fast_interval_i` if `boost_o`, else `interval_i`.
- COUNT:
  - If `enable_i`=0, go to IDLE.
  - Else if `cnt_q`==0, go to WAIT, set `scrub_trigger_o[bank_idx]`, and clear the wait counter.
  - Else decrement `cnt_q`.
- WAIT:
  - The trigger is held while in WAIT. The wait counter increments each cycle.
  - On `scrub_done_i[bank_idx]`: clear the trigger, advance the index modulo `NumBanks`, and decrement the boost counter if nonzero. Go to COUNT, reloading the effective interval, if `enable_i`; otherwise go to IDLE.
  - Timeout: if the wait counter reaches `TimeoutCycles-1` with no done, take the same actions as done, except the boost counter is not decremented, and set `timeout_o`.
  - `enable_i` falling during WAIT does not abort the scrub.
- Done bits for non-selected banks are ignored.
- Boost mode:
  - Any bit of `bit_corrected_i` loads `boost_cnt` with `BoostScrubs`. A reload takes priority over a simultaneous decrement.
  - `boost_o` = (`boost_cnt`≠0).
- Counters:
  - Each cycle, add popcount(`bit_corrected_i`) to the corrected count and popcount(`uncorrectable_i`) to the uncorrectable count. Computation is one bit wider; the counters saturate at all-ones.
  - `clear_i` wins over same-cycle increments; those increments are dropped.
- `irq_o`:
  - Sticky. Set when `uncorrectable_cnt` becomes nonzero, or when `threshold_i`≠0 and `corrected_cnt`≥`threshold_i` (evaluated on the registered counts).
  - Cleared by `clear_i`.
- Interval value 0: the trigger follows the COUNT entry by one cycle.

## Timing
- Reset values:
  - state IDLE;
  - `scrub_trigger_o`=0;
  - `bank_idx_o`=0;
  - `pass_done_o`=0;
  - both counts 0;
  - `boost_o`=0;
  - `timeout_o`=0;
  - `irq_o`=0.
- All outputs are registered.
- Start-up latency with interval I: `enable_i` is first high in cycle 0; COUNT holds `cnt_q`=I from cycle 1; `cnt_q`=0 in cycle I+1; the trigger is high from cycle I+2.
- Done handshake: if done is seen in cycle t, the trigger is low in cycle t+1 and the index is advanced in t+1. The scrubber is therefore in Idle with its trigger low, so there is no double scrub.
- Per-bank cycle: trigger high for (done cycle − rise cycle + 1) cycles, then I+1 cycles in COUNT, then the next trigger.
- Counters and `irq_o` update one cycle after the input pulse. `irq_o` rises one cycle after the count crosses the threshold.
- `pass_done_o` is high in the cycle after the done that wraps the index.
- Asynchronous reset mid-WAIT drops the trigger immediately, and scheduling restarts at bank 0.

## Test plan
- NumBanks=4, I=3, done returned 2 cycles after each trigger rise -> triggers on bank 0,1,2,3,0 in order; first rise in cycle 5; `pass_done_o` pulses once per 4 scrubs.
- `bit_corrected_i`=4'b0101 for one cycle, threshold=2 -> `corrected_cnt_o`=2, `irq_o`=1 the cycle after, `boost_o`=1, and the next `BoostScrubs` scrubs use `fast_interval_i`=1.
- `uncorrectable_i` pulse, then `clear_i` and a simultaneous `bit_corrected_i` pulse -> `irq_o` set then cleared, both counts 0, and boost still reloaded.
- Saturation: CntWidth=4, with `bit_corrected_i`=4'b1111 asserted 5 cycles -> `corrected_cnt_o` holds at 15.
- Done never returned, TimeoutCycles=8 -> trigger drops after 8 high cycles, `timeout_o`=1, index advances to 1.
- `enable_i` dropped during WAIT -> trigger held until done, then IDLE with no further trigger; reset asserted mid-WAIT -> all outputs return to reset values immediately.
